// File: rtl/data_stream_serializer_if.sv
// Word-stream handshake bundle: the producer drives valid/data, the consumer drives ready.
interface data_inf #(
    parameter int DSIZE = 8
) ();
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_stream_serializer.sv
// Word-to-bit serializer: accepts DSIZE-bit words on s_in and shifts them out one bit per
// downstream handshake, reloading on the last bit so consecutive words stream without a gap.
module data_stream_serializer #(
    parameter int DSIZE     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic    clock,
    input  logic    rst_n,
    input  logic    clk_en,
    data_inf.slaver s_in,
    output logic    ser_bit,
    output logic    ser_vld,
    output logic    ser_last,
    input  logic    ser_ready,
    output logic    busy,
    output logic    byte_done
);
    localparam int            CW       = (DSIZE > 2) ? $clog2(DSIZE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DSIZE - 1);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DSIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             byte_done_q, byte_done_d;

    logic             in_shift;
    logic             cnt_zero;
    logic             b_xfer;
    logic             w_xfer;
    logic             in_ready;
    logic             out_bit;
    logic [DSIZE-1:0] shreg_shifted;

    assign in_shift = (state_q == STATE_SHIFT);
    assign cnt_zero = (bit_cnt_q == '0);

    assign ser_vld   = in_shift;
    assign busy      = in_shift;
    assign ser_last  = in_shift && cnt_zero;
    assign byte_done = byte_done_q;

    assign b_xfer = ser_vld && ser_ready && clk_en;

    // Ready also opens while the last bit leaves, so the next word loads with no idle cycle.
    assign in_ready   = rst_n && clk_en &&
                        ((state_q == STATE_IDLE) || (in_shift && b_xfer && cnt_zero));
    assign s_in.ready = in_ready;
    assign w_xfer     = s_in.valid && in_ready && clk_en;

    assign out_bit = MSB_FIRST ? shreg_q[DSIZE-1] : shreg_q[0];
    assign ser_bit = in_shift && out_bit;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[DSIZE-2:0], 1'b0}
                                     : {1'b0, shreg_q[DSIZE-1:1]};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = b_xfer && cnt_zero;

        case (state_q)
            STATE_IDLE: begin
                if (w_xfer) begin
                    shreg_d   = s_in.data;
                    bit_cnt_d = CNT_LOAD;
                    state_d   = STATE_SHIFT;
                end
            end
            STATE_SHIFT: begin
                if (b_xfer) begin
                    if (!cnt_zero) begin
                        shreg_d   = shreg_shifted;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else if (w_xfer) begin
                        shreg_d   = s_in.data;
                        bit_cnt_d = CNT_LOAD;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
        end
    end
endmodule

// File: doc/data_stream_serializer.md
DATA_STREAM_SERIALIZER -- requirements
Module: data_stream_serializer

Interface
REQ-001 Parameter DSIZE, default 8, word width in bits (DSIZE >= 2).
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB first.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 clk_en  input  1  bit-rate enable; no handshake completes while low.
REQ-006 s_in  data_inf.slaver  -  word stream from data_pipe_interconnect m00; s_in.valid in 1, s_in.data in DSIZE, s_in.ready out 1.
REQ-007 ser_bit  output  1  current serial bit.
REQ-008 ser_vld  output  1  ser_bit valid.
REQ-009 ser_last  output  1  ser_bit is the final bit of the word.
REQ-010 ser_ready  input  1  downstream accepts ser_bit.
REQ-011 busy  output  1  word in progress.
REQ-012 byte_done  output  1  one-cycle pulse after a word's last bit transfers.

Function
REQ-013 Word handshake: w_xfer = s_in.valid && s_in.ready && clk_en.
REQ-014 Bit handshake: b_xfer = ser_vld && ser_ready && clk_en.
REQ-015 State machine: two states, IDLE and SHIFT, plus a shift register of DSIZE bits and a bit counter of max(1, clog2(DSIZE)) bits.
REQ-016 s_in.ready = rst_n && clk_en && (state==IDLE || (state==SHIFT && b_xfer && bit_cnt==0)); this path is combinational.
REQ-017 IDLE transitions:
  - on w_xfer: load shreg <= s_in.data, bit_cnt <= DSIZE-1, go to SHIFT.
  - otherwise hold.
REQ-018 SHIFT, b_xfer with bit_cnt != 0:
  - shift shreg one position toward the output end (left if MSB_FIRST, right otherwise), zero fill.
  - decrement bit_cnt.
REQ-019 SHIFT, b_xfer with bit_cnt == 0, i.e. the last bit:
  - if w_xfer in the same cycle, reload from s_in.data, set bit_cnt <= DSIZE-1 and stay in SHIFT (back-to-back words, no gap).
  - else go to IDLE.
REQ-020 SHIFT without b_xfer: shreg, bit_cnt and ser_bit hold stable (covers ser_ready low and clk_en low).
REQ-021 ser_vld = (state==SHIFT).
REQ-022 ser_bit = shreg[DSIZE-1] when MSB_FIRST=1, else shreg[0]; value is don't-care when ser_vld=0 but driven 0 in IDLE.
REQ-023 ser_last = (state==SHIFT && bit_cnt==0).
REQ-024 byte_done is registered: high exactly one cycle after each cycle in which b_xfer occurs with bit_cnt==0.
REQ-025 busy = (state==SHIFT).
REQ-026 Latency: the first bit appears on ser_bit in the cycle after w_xfer; with ser_ready=1 and clk_en=1, one word takes DSIZE cycles.
REQ-027 s_in.data is sampled only on w_xfer; later changes on s_in.data do not affect the word in flight.

Reset
REQ-028 When rst_n=0 at a rising edge:
  - state <= IDLE, shreg <= 0, bit_cnt <= 0, byte_done <= 0.
  - consequently ser_vld=0, ser_last=0, ser_bit=0, busy=0.
REQ-029 s_in.ready = 0 while rst_n=0.
REQ-030 Reset mid-word discards the partial word; no byte_done is generated for it.
REQ-031 After rst_n deasserts, the block accepts a word on the first cycle with clk_en=1.

Verification
REQ-032 Single word. DSIZE=8, MSB_FIRST=1, s_in.data=0xA5, clk_en=1, ser_ready=1:
  - w_xfer at cycle 0.
  - ser_bit = 1,0,1,0,0,1,0,1 over cycles 1-8.
  - ser_last high only in cycle 8.
  - byte_done high in cycle 9; busy low in cycle 9.
REQ-033 Back-to-back. 0xA5 then 0x3C, both valid continuously:
  - 0x3C is accepted in cycle 8.
  - 16 contiguous bits, ending with 0,0,1,1,1,1,0,0.
  - byte_done in cycles 9 and 17.
REQ-034 Backpressure. ser_ready=0 for 3 cycles while bit 4 is presented:
  - ser_bit, ser_vld and bit_cnt stay frozen.
  - the word completes 3 cycles late; the bit sequence is unchanged.
REQ-035 Enable pacing. clk_en high 1 cycle in 4:
  - bits and word acceptance advance only on clk_en cycles.
  - s_in.ready is 0 on cycles where clk_en=0.
REQ-036 LSB first. MSB_FIRST=0, data=0x01:
  - first bit 1, then seven 0s.
  - ser_last on the 8th bit.
REQ-037 Reset mid-word. rst_n=0 for 1 cycle after 3 bits of 0xA5:
  - next cycle: ser_vld=0, busy=0, no byte_done.
  - then word 0xFF: eight 1s, followed by a byte_done pulse.
